// File: rtl/robot_controller.sv
// Pipe-cleaning robot decision core: left-hand wall following with
// priority cleaning, step/clean statistics and spin-in-place detection.
module robot_controller #(
    parameter int STUCK_TURNS = 4,
    parameter int STEP_W      = 16,
    parameter int CLEAN_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sensors_valid,
    input  logic               head,
    input  logic               left,
    input  logic               under,
    output logic               cmd_valid,
    output logic [1:0]         cmd,
    output logic               stuck,
    output logic [2:0]         fsm_state,
    output logic [STEP_W-1:0]  step_count,
    output logic [CLEAN_W-1:0] clean_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEARCH    = 3'd1,
        ST_FOLLOW    = 3'd2,
        ST_POST_LEFT = 3'd3,
        ST_STUCK     = 3'd4
    } state_t;

    localparam logic [1:0] CMD_ADV   = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_CLEAN = 2'b11;

    state_t     state, state_nx;
    logic [3:0] turns, turns_nx;
    logic [1:0] cmd_nx;
    logic       issue;
    logic       is_turn;

    always_comb begin
        state_nx = state;
        cmd_nx   = cmd;
        issue    = 1'b0;
        if (sensors_valid && state != ST_STUCK) begin
            issue = 1'b1;
            case (state)
                ST_FOLLOW: begin
                    if (under) begin
                        cmd_nx = CMD_CLEAN;
                    end else if (!left) begin
                        cmd_nx   = CMD_LEFT;
                        state_nx = ST_POST_LEFT;
                    end else if (!head) begin
                        cmd_nx = CMD_ADV;
                    end else begin
                        cmd_nx = CMD_RIGHT;
                    end
                end
                ST_POST_LEFT: begin
                    if (under) begin
                        cmd_nx = CMD_CLEAN;
                    end else if (!head) begin
                        cmd_nx   = CMD_ADV;
                        state_nx = ST_FOLLOW;
                    end else begin
                        cmd_nx   = CMD_RIGHT;
                        state_nx = ST_FOLLOW;
                    end
                end
                default: begin
                    // IDLE and SEARCH share the search rules
                    if (under) begin
                        cmd_nx   = CMD_CLEAN;
                        state_nx = ST_SEARCH;
                    end else if (left) begin
                        cmd_nx   = head ? CMD_RIGHT : CMD_ADV;
                        state_nx = ST_FOLLOW;
                    end else if (!head) begin
                        cmd_nx   = CMD_ADV;
                        state_nx = ST_SEARCH;
                    end else begin
                        cmd_nx   = CMD_RIGHT;
                        state_nx = ST_FOLLOW;
                    end
                end
            endcase
        end
    end

    assign is_turn = (cmd_nx == CMD_LEFT) || (cmd_nx == CMD_RIGHT);

    always_comb begin
        turns_nx = turns;
        if (issue) begin
            if (cmd_nx == CMD_ADV) begin
                turns_nx = 4'd0;
            end else if (is_turn) begin
                turns_nx = turns + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            turns       <= 4'd0;
            cmd_valid   <= 1'b0;
            cmd         <= CMD_ADV;
            step_count  <= '0;
            clean_count <= '0;
        end else begin
            cmd_valid <= issue;
            turns     <= turns_nx;
            if (issue) begin
                cmd <= cmd_nx;
                // the turn reaching the limit is still issued
                if (is_turn && turns_nx == 4'(STUCK_TURNS)) begin
                    state <= ST_STUCK;
                end else begin
                    state <= state_nx;
                end
                if (cmd_nx == CMD_ADV && step_count != '1) begin
                    step_count <= step_count + 1'b1;
                end
                if (cmd_nx == CMD_CLEAN && clean_count != '1) begin
                    clean_count <= clean_count + 1'b1;
                end
            end
        end
    end

    assign stuck     = (state == ST_STUCK);
    assign fsm_state = state;

endmodule

// File: tb/tb_robot_controller.sv
// Bench for robot_controller: rule-level model compared every cycle,
// plus literal checkpoints; a narrow-counter instance covers saturation.
module tb_robot_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sensors_valid = 1'b0;
    logic       head = 1'b0;
    logic       left = 1'b0;
    logic       under = 1'b0;

    logic        cmd_valid, stuck;
    logic [1:0]  cmd;
    logic [2:0]  fsm_state;
    logic [15:0] step_count;
    logic [7:0]  clean_count;

    logic        cmd_valid2, stuck2;
    logic [1:0]  cmd2;
    logic [2:0]  fsm_state2;
    logic [1:0]  step_count2;
    logic [1:0]  clean_count2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    robot_controller #(.STUCK_TURNS(4), .STEP_W(16), .CLEAN_W(8)) u_dut (
        .clock(clock), .reset(reset), .sensors_valid(sensors_valid),
        .head(head), .left(left), .under(under),
        .cmd_valid(cmd_valid), .cmd(cmd), .stuck(stuck),
        .fsm_state(fsm_state), .step_count(step_count),
        .clean_count(clean_count)
    );

    robot_controller #(.STUCK_TURNS(4), .STEP_W(2), .CLEAN_W(2)) u_sat (
        .clock(clock), .reset(reset), .sensors_valid(sensors_valid),
        .head(head), .left(left), .under(under),
        .cmd_valid(cmd_valid2), .cmd(cmd2), .stuck(stuck2),
        .fsm_state(fsm_state2), .step_count(step_count2),
        .clean_count(clean_count2)
    );

    // mode: 0 idle, 1 search, 2 follow, 3 post-left, 4 stuck
    typedef struct {
        int mode;
        int turns;
        int steps;
        int cleans;
        int steps2;
        int cleans2;
        bit valid;
        int cmd;
    } model_t;

    model_t m = '{default: 0};

    function automatic int sat_inc(int v, int lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    function automatic model_t model_step(model_t cur, bit sv, bit h,
                                          bit l, bit u);
        model_t n;
        int c;
        int nm;
        n = cur;
        n.valid = 1'b0;
        c = 0;
        nm = cur.mode;
        if (!sv || cur.mode == 4) return n;
        case (cur.mode)
            2: begin
                if (u) c = 3;
                else if (!l) begin c = 1; nm = 3; end
                else if (!h) c = 0;
                else c = 2;
            end
            3: begin
                if (u) c = 3;
                else if (!h) begin c = 0; nm = 2; end
                else begin c = 2; nm = 2; end
            end
            default: begin
                if (u) begin c = 3; nm = 1; end
                else if (l) begin c = h ? 2 : 0; nm = 2; end
                else if (!h) begin c = 0; nm = 1; end
                else begin c = 2; nm = 2; end
            end
        endcase
        n.valid = 1'b1;
        n.cmd = c;
        n.mode = nm;
        if (c == 0) begin
            n.steps = sat_inc(cur.steps, 65535);
            n.steps2 = sat_inc(cur.steps2, 3);
            n.turns = 0;
        end else if (c == 3) begin
            n.cleans = sat_inc(cur.cleans, 255);
            n.cleans2 = sat_inc(cur.cleans2, 3);
        end else begin
            n.turns = cur.turns + 1;
            if (n.turns == 4) n.mode = 4;
        end
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= '{default: 0};
        else m <= model_step(m, sensors_valid, head, left, under);
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmd_valid", int'(cmd_valid), int'(m.valid));
            check("cmd", int'(cmd), m.cmd);
            check("stuck", int'(stuck), int'(m.mode == 4));
            check("fsm_state", int'(fsm_state), m.mode);
            check("step_count", int'(step_count), m.steps);
            check("clean_count", int'(clean_count), m.cleans);
            check("sat_cmd_valid", int'(cmd_valid2), int'(m.valid));
            check("sat_state", int'(fsm_state2), m.mode);
            check("sat_step_count", int'(step_count2), m.steps2);
            check("sat_clean_count", int'(clean_count2), m.cleans2);
        end
    end

    task automatic drive(bit v, bit h, bit l, bit u);
        @(negedge clock);
        sensors_valid = v;
        head = h;
        left = l;
        under = u;
    endtask

    initial begin
        chk_en = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_state", int'(fsm_state), 0);
        reset = 1'b1;

        // open field, back-to-back pulses
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        check("open_steps", int'(step_count), 3);
        check("open_state", int'(fsm_state), 1);
        check("open_cmd", int'(cmd), 0);
        drive(1, 0, 1, 0);
        check("wall_cmd", int'(cmd), 2);
        check("wall_state", int'(fsm_state), 2);
        drive(1, 1, 0, 1);
        check("follow_adv_steps", int'(step_count), 4);
        drive(1, 0, 0, 0);
        check("dirt_cmd", int'(cmd), 3);
        check("dirt_clean", int'(clean_count), 1);
        check("dirt_state", int'(fsm_state), 2);
        drive(1, 0, 0, 1);
        check("left_cmd", int'(cmd), 1);
        check("left_state", int'(fsm_state), 3);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 0);
        check("sat_clean_lit", int'(clean_count2), 3);
        check("wide_clean_lit", int'(clean_count), 5);
        check("post_left_stay", int'(fsm_state), 3);
        drive(1, 1, 1, 0);
        check("post_adv_state", int'(fsm_state), 2);
        check("sat_step_lit", int'(step_count2), 3);

        // spin in place
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 0, 0, 0);
        check("stuck_flag", int'(stuck), 1);
        check("stuck_state", int'(fsm_state), 4);
        check("stuck_last_cmd", int'(cmd), 2);
        drive(0, 0, 0, 0);
        check("stuck_no_cmd", int'(cmd_valid), 0);
        repeat (2) @(negedge clock);

        // recover, then reset in the cycle a command would rise
        reset = 1'b0;
        drive(0, 0, 0, 0);
        reset = 1'b1;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        #2 reset = 1'b0;
        drive(0, 0, 0, 0);
        check("mid_rst_valid", int'(cmd_valid), 0);
        check("mid_rst_steps", int'(step_count), 0);
        check("mid_rst_state", int'(fsm_state), 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("in_rst_pulse", int'(cmd_valid), 0);
        reset = 1'b1;
        drive(1, 1, 0, 0);
        drive(1, 1, 1, 0);
        check("rel_cmd", int'(cmd), 2);
        check("rel_state", int'(fsm_state), 2);
        drive(1, 0, 0, 1);
        check("rel_follow_right", int'(cmd), 2);
        drive(0, 0, 0, 0);
        check("rel_clean", int'(clean_count), 1);
        repeat (3) @(negedge clock);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
